// File: rtl/sba_arbiter_pkg.sv
// Shared definitions for the SBA two-master arbiter: state encoding,
// master indices and bus widths.
package sba_arbiter_pkg;

    localparam int SBA_AW  = 32;
    localparam int SBA_DW  = 32;
    localparam int SBA_WEW = 4;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sba_state_e;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == M_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sba_rr_pick.sv
// Two-way round-robin select: a lone requester wins, contention goes to
// the master that was not served last.
module sba_rr_pick
    import sba_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       owner
);

    always_comb begin
        owner = M_CPU;
        case (req)
            2'b10:   owner = M_DMA;
            2'b11:   owner = ~last;
            default: owner = M_CPU;
        endcase
    end

endmodule

// File: rtl/sba_arbiter.sv
// SBA two-master arbiter: round-robin grant, one idle cycle between
// transactions, and error termination of unacknowledged transactions.
module sba_arbiter
    import sba_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_m0_stb,
    input  logic [SBA_WEW-1:0] i_m0_we,
    input  logic [SBA_AW-1:0]  i_m0_addr,
    input  logic [SBA_DW-1:0]  i_m0_dat_w,
    output logic [SBA_DW-1:0]  o_m0_dat_r,
    output logic               o_m0_ack,
    output logic               o_m0_err,
    input  logic               i_m1_stb,
    input  logic [SBA_WEW-1:0] i_m1_we,
    input  logic [SBA_AW-1:0]  i_m1_addr,
    input  logic [SBA_DW-1:0]  i_m1_dat_w,
    output logic [SBA_DW-1:0]  o_m1_dat_r,
    output logic               o_m1_ack,
    output logic               o_m1_err,
    output logic               o_stb,
    output logic [SBA_WEW-1:0] o_we,
    output logic [SBA_AW-1:0]  o_addr,
    output logic [SBA_DW-1:0]  o_dat_w,
    input  logic [SBA_DW-1:0]  i_dat_r,
    input  logic               i_ack,
    output logic [1:0]         o_grant,
    output logic [SBA_AW-1:0]  o_err_addr,
    output logic               o_err_src
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    sba_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SBA_AW-1:0] err_addr_q, err_addr_d;
    logic              err_src_q, err_src_d;

    logic               pick_owner;
    logic               own_stb;
    logic [SBA_WEW-1:0] own_we;
    logic [SBA_AW-1:0]  own_addr;
    logic [SBA_DW-1:0]  own_dat_w;
    logic               ack_c;
    logic               err_c;
    logic               rd_en_c;

    sba_rr_pick u_pick (
        .req   ({i_m1_stb, i_m0_stb}),
        .last  (last_q),
        .owner (pick_owner)
    );

    assign own_stb   = (owner_q == M_DMA) ? i_m1_stb   : i_m0_stb;
    assign own_we    = (owner_q == M_DMA) ? i_m1_we    : i_m0_we;
    assign own_addr  = (owner_q == M_DMA) ? i_m1_addr  : i_m0_addr;
    assign own_dat_w = (owner_q == M_DMA) ? i_m1_dat_w : i_m0_dat_w;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        err_src_d  = err_src_q;
        o_stb      = 1'b0;
        o_we       = '0;
        o_addr     = '0;
        o_dat_w    = '0;
        o_grant    = 2'b00;
        ack_c      = 1'b0;
        err_c      = 1'b0;
        rd_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Slave ack is deliberately ignored here; it cannot belong to anyone.
                if (i_m0_stb || i_m1_stb) begin
                    owner_d = pick_owner;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_stb   = own_stb;
                o_we    = own_we;
                o_addr  = own_addr;
                o_dat_w = own_dat_w;
                o_grant = owner_onehot(owner_q);
                rd_en_c = 1'b1;
                if (!own_stb) begin
                    state_d = ST_IDLE;
                end else if (i_ack) begin
                    ack_c   = 1'b1;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    ack_c      = 1'b1;
                    err_c      = 1'b1;
                    rd_en_c    = 1'b0;
                    err_addr_d = own_addr;
                    err_src_d  = owner_q;
                    last_d     = owner_q;
                    state_d    = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_m0_ack   = ack_c && (owner_q == M_CPU);
    assign o_m1_ack   = ack_c && (owner_q == M_DMA);
    assign o_m0_err   = err_c && (owner_q == M_CPU);
    assign o_m1_err   = err_c && (owner_q == M_DMA);
    assign o_m0_dat_r = (rd_en_c && owner_q == M_CPU) ? i_dat_r : '0;
    assign o_m1_dat_r = (rd_en_c && owner_q == M_DMA) ? i_dat_r : '0;
    assign o_err_addr = err_addr_q;
    assign o_err_src  = err_src_q;

    // last resets to DMA so the CPU wins the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= M_CPU;
            last_q     <= M_DMA;
            cnt_q      <= '0;
            err_addr_q <= '0;
            err_src_q  <= M_CPU;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            err_src_q  <= err_src_d;
        end
    end

endmodule

// File: tb/tb_sba_arbiter.sv
// Bench for sba_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_sba_arbiter;

    localparam int TIMEOUT = 255;
    localparam int CW      = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        m_stb  [2];
    logic [3:0]  m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_dat  [2];
    logic [31:0] o_m0_dat_r, o_m1_dat_r;
    logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
    logic        o_stb;
    logic [3:0]  o_we;
    logic [31:0] o_addr, o_dat_w;
    logic [31:0] s_dat;
    logic        s_ack;
    logic [1:0]  o_grant;
    logic [31:0] o_err_addr;
    logic        o_err_src;

    always #5 i_clk = ~i_clk;

    sba_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_m0_stb   (m_stb[0]),
        .i_m0_we    (m_we[0]),
        .i_m0_addr  (m_addr[0]),
        .i_m0_dat_w (m_dat[0]),
        .o_m0_dat_r (o_m0_dat_r),
        .o_m0_ack   (o_m0_ack),
        .o_m0_err   (o_m0_err),
        .i_m1_stb   (m_stb[1]),
        .i_m1_we    (m_we[1]),
        .i_m1_addr  (m_addr[1]),
        .i_m1_dat_w (m_dat[1]),
        .o_m1_dat_r (o_m1_dat_r),
        .o_m1_ack   (o_m1_ack),
        .o_m1_err   (o_m1_err),
        .o_stb      (o_stb),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_dat_w    (o_dat_w),
        .i_dat_r    (s_dat),
        .i_ack      (s_ack),
        .o_grant    (o_grant),
        .o_err_addr (o_err_addr),
        .o_err_src  (o_err_src)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: who holds the bus (-1 = nobody) and for how many cycles.
    int          cur;
    int          age;
    int          last_srv;
    logic [31:0] r_err_addr;
    int          r_err_src;
    int          outcome;        // 0 continue, 1 slave ack, 2 timeout, 3 abort
    bit          e_ack [2];
    bit          prev_ack [2];
    bit          rand_mode = 0;
    bit          slv_auto  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:28] == 4'h4;
    endfunction

    task automatic model_reset();
        cur        = -1;
        age        = 0;
        last_srv   = 1;
        r_err_addr = '0;
        r_err_src  = 0;
    endtask

    task automatic drive_and_check();
        logic        x_stb;
        logic [3:0]  x_we;
        logic [31:0] x_addr, x_dw;
        logic [31:0] x_dr [2];
        logic [1:0]  x_grant;
        bit          x_err [2];
        x_stb = 0; x_we = 0; x_addr = 0; x_dw = 0; x_grant = 0;
        x_dr[0] = 0; x_dr[1] = 0;
        outcome = 0;
        for (int i = 0; i < 2; i++) begin e_ack[i] = 0; x_err[i] = 0; end
        if (cur >= 0) begin
            x_stb  = m_stb[cur];
            x_we   = m_we[cur];
            x_addr = m_addr[cur];
            x_dw   = m_dat[cur];
        end
        if (slv_auto) begin
            s_dat = $urandom;
            if (x_stb) s_ack = !unmapped(x_addr) && ($urandom_range(2) == 0);
            else       s_ack = ($urandom_range(7) == 0);
        end
        if (cur >= 0) begin
            x_grant  = (cur == 0) ? 2'b01 : 2'b10;
            x_dr[cur] = s_dat;
            if (!m_stb[cur]) outcome = 3;
            else if (s_ack) begin
                outcome = 1;
                e_ack[cur] = 1;
            end else if (age == TIMEOUT) begin
                outcome = 2;
                e_ack[cur] = 1;
                x_err[cur] = 1;
                x_dr[cur]  = 0;
            end
        end
        #1;
        chk("stb", o_stb, x_stb);
        chk("we", o_we, x_we);
        chk("addr", o_addr, x_addr);
        chk("dat_w", o_dat_w, x_dw);
        chk("grant", o_grant, x_grant);
        chk("m0_ack", o_m0_ack, e_ack[0]);
        chk("m1_ack", o_m1_ack, e_ack[1]);
        chk("m0_err", o_m0_err, x_err[0]);
        chk("m1_err", o_m1_err, x_err[1]);
        chk("m0_dat_r", o_m0_dat_r, x_dr[0]);
        chk("m1_dat_r", o_m1_dat_r, x_dr[1]);
        chk("err_addr", o_err_addr, r_err_addr);
        chk("err_src", o_err_src, r_err_src[0]);
    endtask

    task automatic advance();
        @(posedge i_clk);
        if (i_rst) model_reset();
        else if (cur < 0) begin
            if (m_stb[0] && m_stb[1]) cur = 1 - last_srv;
            else if (m_stb[0])        cur = 0;
            else if (m_stb[1])        cur = 1;
            age = 0;
        end else begin
            case (outcome)
                1: begin last_srv = cur; cur = -1; end
                2: begin
                    r_err_addr = m_addr[cur];
                    r_err_src  = cur;
                    last_srv   = cur;
                    cur        = -1;
                end
                3: cur = -1;
                default: if (age < 2**CW - 1) age++;
            endcase
        end
        @(negedge i_clk);
        for (int i = 0; i < 2; i++) begin
            prev_ack[i] = e_ack[i];
            if (e_ack[i]) m_stb[i] = 0;
            else if (rand_mode) begin
                if (!m_stb[i]) begin
                    if ($urandom_range(3) == 0) begin
                        m_stb[i]  = 1;
                        m_addr[i] = ($urandom_range(39) == 0) ? (32'h4000_0000 | ($urandom & 32'h0000_FFFC))
                                                             : ($urandom & 32'h3FFF_FFFC);
                        m_we[i]   = 4'($urandom);
                        m_dat[i]  = $urandom;
                    end
                end else if ($urandom_range(99) == 0) m_stb[i] = 0;
            end
        end
    endtask

    task automatic cyc();
        drive_and_check();
        advance();
    endtask

    task automatic do_reset();
        i_rst = 1;
        for (int i = 0; i < 2; i++) begin m_stb[i] = 0; prev_ack[i] = 0; e_ack[i] = 0; end
        s_ack = 0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 0;
    endtask

    logic [1:0] grants [$];
    logic [1:0] g_prev;
    bit         seen;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_stb[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_dat[i] = 0;
        end
        s_dat = 0;
        do_reset();

        // reset state
        drive_and_check();
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_err_addr", o_err_addr, 32'h0);
        advance();

        // single CPU read
        m_stb[0] = 1; m_addr[0] = 32'h0000_0010; m_we[0] = 4'h0; m_dat[0] = 0;
        drive_and_check();
        chk("t1_idle_stb", o_stb, 1'b0);
        advance();
        drive_and_check();
        chk("t1_stb_rise", o_stb, 1'b1);
        advance();
        s_ack = 1; s_dat = 32'hDEAD_BEEF;
        drive_and_check();
        chk("t1_ack", o_m0_ack, 1'b1);
        chk("t1_dat", o_m0_dat_r, 32'hDEAD_BEEF);
        chk("t1_m1_ack", o_m1_ack, 1'b0);
        advance();
        s_ack = 0;
        drive_and_check();
        chk("t1_gap", o_stb, 1'b0);
        advance();

        // contention from reset, immediate slave ack
        do_reset();
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
        m_stb[0] = 1; m_stb[1] = 1; s_ack = 1; g_prev = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 2; i++) if (!m_stb[i] && !prev_ack[i]) m_stb[i] = 1;
            drive_and_check();
            if (o_grant != 2'b00 && g_prev == 2'b00) grants.push_back(o_grant);
            g_prev = o_grant;
            advance();
        end
        chk("t2_count", 64'(grants.size() >= 4), 64'd1);
        if (grants.size() >= 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("t2_grant%0d", k), grants[k], (k % 2 == 1) ? 2'b10 : 2'b01);
        m_stb[0] = 0; m_stb[1] = 0; s_ack = 0;
        cyc(); cyc();

        // DMA write
        m_stb[1] = 1; m_addr[1] = 32'h8000_0004; m_we[1] = 4'b0011; m_dat[1] = 32'hA5A5_1234;
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive_and_check();
            chk("t3_addr", o_addr, 32'h8000_0004);
            chk("t3_dat_w", o_dat_w, 32'hA5A5_1234);
            chk("t3_we", o_we, 4'b0011);
            chk("t3_grant", o_grant, 2'b10);
            advance();
        end
        s_ack = 1;
        drive_and_check();
        chk("t3_ack", o_m1_ack, 1'b1);
        chk("t3_m0_ack", o_m0_ack, 1'b0);
        advance();
        s_ack = 0;
        cyc();

        // timeout on unmapped address
        m_stb[0] = 1; m_addr[0] = 32'h4000_0000; m_we[0] = 0; s_dat = 32'h1234_5678;
        cyc();
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            drive_and_check();
            if (o_m0_ack) begin
                seen = 1;
                chk("t4_dist", k, TIMEOUT);
                chk("t4_err", o_m0_err, 1'b1);
                chk("t4_dat_r", o_m0_dat_r, 32'h0);
                advance();
                break;
            end
            advance();
        end
        if (!seen) chk("t4_to_seen", 1'b0, 1'b1);
        chk("t4_err_addr", o_err_addr, 32'h4000_0000);
        chk("t4_err_src", o_err_src, 1'b0);
        cyc();

        // slave ack coincides with timeout
        m_stb[1] = 1; m_addr[1] = 32'h0000_0100; m_we[1] = 4'hF;
        cyc();
        for (int k = 0; k <= TIMEOUT; k++) begin
            s_ack = (k == TIMEOUT);
            drive_and_check();
            if (k == TIMEOUT) begin
                chk("t5_ack", o_m1_ack, 1'b1);
                chk("t5_err", o_m1_err, 1'b0);
            end
            advance();
        end
        s_ack = 0;
        chk("t5_err_addr", o_err_addr, 32'h4000_0000);
        chk("t5_err_src", o_err_src, 1'b0);
        cyc();

        // asynchronous reset mid-transaction
        m_stb[0] = 1; m_addr[0] = 32'h0000_0020;
        cyc(); cyc();
        drive_and_check();
        i_rst = 1;
        #1;
        chk("t5_rst_stb", o_stb, 1'b0);
        chk("t5_rst_grant", o_grant, 2'b00);
        chk("t5_rst_ack", o_m0_ack, 1'b0);
        model_reset();
        m_stb[0] = 0; m_stb[1] = 0;
        advance();
        i_rst = 0;
        cyc();

        // owner aborts while the other master waits
        m_stb[0] = 1; m_addr[0] = 32'h0000_0030;
        m_stb[1] = 1; m_addr[1] = 32'h0000_0034;
        cyc(); cyc();
        m_stb[0] = 0;
        drive_and_check();
        chk("t6_no_ack", o_m0_ack, 1'b0);
        advance();
        drive_and_check();
        chk("t6_idle", o_grant, 2'b00);
        advance();
        drive_and_check();
        chk("t6_m1_grant", o_grant, 2'b10);
        chk("t6_m1_stb", o_stb, 1'b1);
        advance();
        s_ack = 1;
        cyc();
        s_ack = 0;
        cyc();

        // random traffic
        rand_mode = 1; slv_auto = 1;
        repeat (4000) cyc();
        rand_mode = 0; slv_auto = 0; s_ack = 0;
        m_stb[0] = 0; m_stb[1] = 0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
